// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich parameter loader.
// Holds frame defaults, the loader FSM encoding and the preset parameter table.
package izh_pkg;

    localparam int          DEF_TIMEOUT_CYCLES = 200;
    localparam logic [7:0]  DEF_FRAME_HEADER   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_GET_C = 3'd3,
        ST_GET_D = 3'd4,
        ST_GET_CK = 3'd5
    } izh_state_t;

    // Preset parameters packed as {a, b, c, d}.
    localparam logic [31:0] PRESET_RS = 32'h02_33_00_08;
    localparam logic [31:0] PRESET_FS = 32'h0D_33_00_02;
    localparam logic [31:0] PRESET_CH = 32'h02_33_0F_02;
    localparam logic [31:0] PRESET_IB = 32'h02_33_05_04;

    function automatic logic [31:0] preset_params(input logic [1:0] sel);
        logic [31:0] p;
        case (sel)
            2'd0:    p = PRESET_RS;
            2'd1:    p = PRESET_FS;
            2'd2:    p = PRESET_CH;
            default: p = PRESET_IB;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/izh_param_loader.sv
// Loads Izhikevich neuron parameters from a checksummed byte frame or a preset table.
// Outputs only change on a whole validated frame or a preset commit.
module izh_param_loader
    import izh_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0] FRAME_HEADER   = DEF_FRAME_HEADER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic [1:0] preset_sel,
    input  logic       preset_load,
    output logic [7:0] param_a,
    output logic [7:0] param_b,
    output logic [7:0] param_c,
    output logic [7:0] param_d,
    output logic       params_ready,
    output logic       load_busy,
    output logic       load_error,
    output logic [2:0] fsm_state
);

    // Handshake: a byte is transferred on every rising edge where data_valid=1;
    // there is no ready/backpressure, the loader accepts every strobed byte.

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    izh_state_t state;
    logic [7:0] shadow_a;
    logic [7:0] shadow_b;
    logic [7:0] shadow_c;
    logic [7:0] shadow_d;
    logic [7:0] idle_count;
    logic [7:0] frame_xor;

    assign frame_xor = shadow_a ^ shadow_b ^ shadow_c ^ shadow_d;
    assign load_busy = (state != ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            shadow_a     <= 8'h00;
            shadow_b     <= 8'h00;
            shadow_c     <= 8'h00;
            shadow_d     <= 8'h00;
            idle_count   <= 8'h00;
            param_a      <= 8'h00;
            param_b      <= 8'h00;
            param_c      <= 8'h00;
            param_d      <= 8'h00;
            params_ready <= 1'b0;
            load_error   <= 1'b0;
        end else if (state == ST_IDLE) begin
            idle_count <= 8'h00;
            // A preset request takes priority over a simultaneous byte.
            if (preset_load) begin
                {param_a, param_b, param_c, param_d} <= preset_params(preset_sel);
                params_ready <= 1'b1;
                load_error   <= 1'b0;
            end else if (data_valid && data_in == FRAME_HEADER) begin
                state <= ST_GET_A;
            end
        end else if (data_valid) begin
            idle_count <= 8'h00;
            case (state)
                ST_GET_A: begin
                    shadow_a <= data_in;
                    state    <= ST_GET_B;
                end
                ST_GET_B: begin
                    shadow_b <= data_in;
                    state    <= ST_GET_C;
                end
                ST_GET_C: begin
                    shadow_c <= data_in;
                    state    <= ST_GET_D;
                end
                ST_GET_D: begin
                    shadow_d <= data_in;
                    state    <= ST_GET_CK;
                end
                ST_GET_CK: begin
                    if (data_in == frame_xor) begin
                        param_a      <= shadow_a;
                        param_b      <= shadow_b;
                        param_c      <= shadow_c;
                        param_d      <= shadow_d;
                        params_ready <= 1'b1;
                        load_error   <= 1'b0;
                    end else begin
                        load_error <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end else if ({1'b0, idle_count} + 9'd1 == TIMEOUT_LIMIT) begin
            state      <= ST_IDLE;
            load_error <= 1'b1;
            idle_count <= 8'h00;
            shadow_a   <= 8'h00;
            shadow_b   <= 8'h00;
            shadow_c   <= 8'h00;
            shadow_d   <= 8'h00;
        end else begin
            idle_count <= idle_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_izh_param_loader.sv
// Directed self-checking bench for izh_param_loader.
// Each scenario task drives frames/presets and compares against hand-computed values.
module tb_izh_param_loader;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic [1:0] preset_sel;
    logic       preset_load;
    logic [7:0] param_a;
    logic [7:0] param_b;
    logic [7:0] param_c;
    logic [7:0] param_d;
    logic       params_ready;
    logic       load_busy;
    logic       load_error;
    logic [2:0] fsm_state;

    int tests_run;
    int tests_failed;

    izh_param_loader dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .preset_sel  (preset_sel),
        .preset_load (preset_load),
        .param_a     (param_a),
        .param_b     (param_b),
        .param_c     (param_c),
        .param_d     (param_d),
        .params_ready(params_ready),
        .load_busy   (load_busy),
        .load_error  (load_error),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] ck);
        send_byte(8'hA5); tick();
        send_byte(a);     tick();
        send_byte(b);     tick();
        send_byte(c);     tick();
        send_byte(d);     tick();
        send_byte(ck);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_params got=%h want=%h", {param_a, param_b, param_c, param_d}, 32'h0);
        end
        tests_run++;
        if ({params_ready, load_busy, load_error, fsm_state} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b want=%b", {params_ready, load_busy, load_error, fsm_state}, 6'b0);
        end
    endtask

    task automatic test_idle_ignore();
        send_byte(8'h00);
        send_byte(8'hFF);
        tests_run++;
        if ({load_busy, load_error, fsm_state} !== 5'b0) begin
            tests_failed++;
            $display("FAIL idle_ignore got=%b want=%b", {load_busy, load_error, fsm_state}, 5'b0);
        end
    endtask

    task automatic test_frame_ok();
        send_byte(8'hA5); tick();
        send_byte(8'h02); tick();
        send_byte(8'h33); tick();
        tests_run++;
        if (load_busy !== 1'b1 || {param_a, param_b, param_c, param_d} !== 32'h0) begin
            tests_failed++;
            $display("FAIL frame_partial busy=%b params=%h want busy=1 params=%h",
                     load_busy, {param_a, param_b, param_c, param_d}, 32'h0);
        end
        send_byte(8'h00); tick();
        send_byte(8'h08); tick();
        send_byte(8'h39);
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02_33_00_08) begin
            tests_failed++;
            $display("FAIL frame_ok_params got=%h want=%h", {param_a, param_b, param_c, param_d}, 32'h02_33_00_08);
        end
        tests_run++;
        if ({params_ready, load_error, load_busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL frame_ok_flags got=%b want=%b", {params_ready, load_error, load_busy}, 3'b100);
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02_33_00_08 ||
            {params_ready, load_error, load_busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL bad_ck got=%h/%b want=%h/%b", {param_a, param_b, param_c, param_d},
                     {params_ready, load_error, load_busy}, 32'h02_33_00_08, 3'b110);
        end
        tick();
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h11_22_33_44 || load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_ck_recover got=%h/%b want=%h/0", {param_a, param_b, param_c, param_d},
                     load_error, 32'h11_22_33_44);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 199; i++) begin
            // Preset requests mid-frame must be ignored.
            preset_load = (i == 50);
            preset_sel  = 2'd3;
            tick();
        end
        preset_load = 1'b0;
        tests_run++;
        if (load_busy !== 1'b1 || load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early busy=%b err=%b want busy=1 err=0", load_busy, load_error);
        end
        tick();
        tests_run++;
        if ({load_busy, load_error, fsm_state} !== 5'b01000) begin
            tests_failed++;
            $display("FAIL timeout_abort got=%b want=%b", {load_busy, load_error, fsm_state}, 5'b01000);
        end
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h11_22_33_44) begin
            tests_failed++;
            $display("FAIL timeout_params got=%h want=%h", {param_a, param_b, param_c, param_d}, 32'h11_22_33_44);
        end
        tick();
        send_frame(8'h0D, 8'h33, 8'h0F, 8'h02, 8'h33);
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h0D_33_0F_02 || load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_recover got=%h/%b want=%h/0", {param_a, param_b, param_c, param_d},
                     load_error, 32'h0D_33_0F_02);
        end
    endtask

    task automatic test_preset();
        logic [31:0] want [4];
        want[0] = 32'h02_33_00_08;
        want[1] = 32'h0D_33_00_02;
        want[2] = 32'h02_33_0F_02;
        want[3] = 32'h02_33_05_04;
        tick();
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        tick();
        // Preset wins over a simultaneous header byte, which is dropped.
        preset_sel  = 2'd1;
        preset_load = 1'b1;
        data_in     = 8'hA5;
        data_valid  = 1'b1;
        tick();
        preset_load = 1'b0;
        data_valid  = 1'b0;
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== want[1] ||
            {params_ready, load_error, load_busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL preset_collide got=%h/%b want=%h/%b", {param_a, param_b, param_c, param_d},
                     {params_ready, load_error, load_busy}, want[1], 3'b100);
        end
        for (int s = 0; s < 4; s++) begin
            preset_sel  = 2'(s);
            preset_load = 1'b1;
            tick();
            preset_load = 1'b0;
            tests_run++;
            if ({param_a, param_b, param_c, param_d} !== want[s]) begin
                tests_failed++;
                $display("FAIL preset_%0d got=%h want=%h", s, {param_a, param_b, param_c, param_d}, want[s]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5); tick();
        send_byte(8'h02); tick();
        send_byte(8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h0 ||
            {params_ready, load_busy, load_error, fsm_state} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_mid got=%h/%b want=%h/%b", {param_a, param_b, param_c, param_d},
                     {params_ready, load_busy, load_error, fsm_state}, 32'h0, 6'b0);
        end
        send_frame(8'h02, 8'h33, 8'h0F, 8'h02, 8'h3C);
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02_33_0F_02 || params_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_recover got=%h/%b want=%h/1", {param_a, param_b, param_c, param_d},
                     params_ready, 32'h02_33_0F_02);
        end
    endtask

    task automatic test_header_as_data();
        tick();
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        tests_run++;
        if ({param_a, param_b, param_c, param_d} !== 32'hA5_A5_A5_A5 ||
            {load_error, load_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL header_data got=%h/%b want=%h/00", {param_a, param_b, param_c, param_d},
                     {load_error, load_busy}, 32'hA5_A5_A5_A5);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        data_in      = 8'h00;
        data_valid   = 1'b0;
        preset_sel   = 2'd0;
        preset_load  = 1'b0;
        #1;
        test_reset();
        test_idle_ignore();
        test_frame_ok();
        test_bad_checksum();
        test_timeout();
        test_preset();
        test_reset_mid_frame();
        test_header_as_data();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
